// File: rtl/adaptive_box_pkg.sv
// Shared types and sizing helpers for the adaptive box-threshold stage.
package adaptive_box_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int kSize(input int radius);
      return 2 * radius + 1;
   endfunction

   function automatic int nTaps(input int radius);
      return kSize(radius) * kSize(radius);
   endfunction

   function automatic int sumBits(input int radius);
      return 8 + $clog2(nTaps(radius));
   endfunction

   // Wide enough for both the raw sum and (p + C) * N without truncation.
   function automatic int cmpBits(input int radius, input int cBits);
      int a;
      int b;
      a = sumBits(radius);
      b = 8 + cBits + 1 + $clog2(nTaps(radius));
      return (a > b) ? a : b;
   endfunction

   function automatic int clampCoord(input int pos, input int maxPos);
      if (pos < 0) begin
         return 0;
      end else if (pos > maxPos) begin
         return maxPos;
      end else begin
         return pos;
      end
   endfunction

endpackage

// File: rtl/adaptive_box_threshold_if.sv
// ROM read port and result RAM write port of the box-threshold stage.
interface adaptive_box_threshold_if #(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8
);
   logic [WIDTH_BITS-1:0]  oImageCol;
   logic [HEIGHT_BITS-1:0] oImageRow;
   logic [7:0]             iImageData;
   logic [WIDTH_BITS-1:0]  oResultCol;
   logic [HEIGHT_BITS-1:0] oResultRow;
   logic                   oResultData;
   logic                   oResultWren;

   modport master (
      output oImageCol, oImageRow,
      input  iImageData,
      output oResultCol, oResultRow, oResultData, oResultWren
   );

   modport slave (
      input  oImageCol, oImageRow,
      output iImageData,
      input  oResultCol, oResultRow, oResultData, oResultWren
   );
endinterface

// File: rtl/box_window_addr_gen.sv
// Walks the K x K window taps (dx fastest) and emits edge-clamped ROM coordinates.
module box_window_addr_gen
   import adaptive_box_pkg::*;
#(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8,
   parameter int RADIUS      = 1
) (
   input  logic                   clock,
   input  logic                   not_reset,
   input  logic                   start,
   input  logic                   advance,
   input  logic [WIDTH_BITS-1:0]  baseCol,
   input  logic [HEIGHT_BITS-1:0] baseRow,
   output logic [WIDTH_BITS-1:0]  tapCol,
   output logic [HEIGHT_BITS-1:0] tapRow,
   output logic                   lastTap,
   output logic                   centreTap
);
   localparam int K  = kSize(RADIUS);
   localparam int IW = $clog2(K);

   logic [IW-1:0]          dx, dy, dxNext, dyNext;
   logic [WIDTH_BITS-1:0]  colClamped;
   logic [HEIGHT_BITS-1:0] rowClamped;

   // Next tap index: restart on start, step dx then dy on advance.
   always_comb begin
      dxNext = dx;
      dyNext = dy;
      if (start) begin
         dxNext = '0;
         dyNext = '0;
      end else if (advance) begin
         if (dx == IW'(K - 1)) begin
            dxNext = '0;
            dyNext = dy + IW'(1);
         end else begin
            dxNext = dx + IW'(1);
         end
      end else begin
         dxNext = dx;
         dyNext = dy;
      end
   end

   assign colClamped = WIDTH_BITS'(clampCoord(int'(baseCol) + int'(dxNext) - RADIUS,
                                              (2 ** WIDTH_BITS) - 1));
   assign rowClamped = HEIGHT_BITS'(clampCoord(int'(baseRow) + int'(dyNext) - RADIUS,
                                               (2 ** HEIGHT_BITS) - 1));

   // Address and flags only move when a tap is issued, so skipped pixels leave the ROM idle.
   always_ff @(posedge clock) begin
      if (!not_reset) begin
         dx        <= '0;
         dy        <= '0;
         tapCol    <= '0;
         tapRow    <= '0;
         lastTap   <= 1'b0;
         centreTap <= 1'b0;
      end else if (start || advance) begin
         dx        <= dxNext;
         dy        <= dyNext;
         tapCol    <= colClamped;
         tapRow    <= rowClamped;
         lastTap   <= (dxNext == IW'(K - 1)) && (dyNext == IW'(K - 1));
         centreTap <= (dxNext == IW'(RADIUS)) && (dyNext == IW'(RADIUS));
      end
   end
endmodule

// File: rtl/adaptive_box_threshold.sv
// Raster-scan box-sum adaptive threshold: result = ((p + C) * N > sum) ^ invert.
// Optional ADAPTIVE_BOX_SKIP_BORDER_EN writes border pixels as 1 ^ invert without ROM reads.
module adaptive_box_threshold
   import adaptive_box_pkg::*;
#(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8,
   parameter int RADIUS      = 1,
   parameter int C_BITS      = 5
) (
   input  logic                      clock,
   input  logic                      not_reset,
   input  logic                      processing,
   input  logic [C_BITS-1:0]         C,
   input  logic                      invert,
   output logic                      finished,
   adaptive_box_threshold_if.master  bus
);
   localparam int N     = nTaps(RADIUS);
   localparam int SUM_W = sumBits(RADIUS);
   localparam int CMP_W = cmpBits(RADIUS, C_BITS);

   state_t                 state;
   logic [WIDTH_BITS-1:0]  pixCol, nextCol, baseCol, tapCol;
   logic [HEIGHT_BITS-1:0] pixRow, nextRow, baseRow, tapRow;
   logic [SUM_W-1:0]       sum, sumFinal;
   logic [7:0]             p, pFinal;
   logic                   dataValid, centreValid, lastTap, centreTap;
   logic                   lastPixel, nextBorder, startScan, advance, brighter;

   // Pixel stepping, window base and the threshold decision on the final tap.
   always_comb begin
      lastPixel = (&pixCol) && (&pixRow);
      nextCol   = pixCol + WIDTH_BITS'(1);
      nextRow   = (&pixCol) ? (pixRow + HEIGHT_BITS'(1)) : pixRow;
      if (state == IDLE) begin
         baseCol = '0;
         baseRow = '0;
      end else if (state == WRITE) begin
         baseCol = nextCol;
         baseRow = nextRow;
      end else begin
         baseCol = pixCol;
         baseRow = pixRow;
      end
      sumFinal = sum + SUM_W'(bus.iImageData);
      pFinal   = centreValid ? bus.iImageData : p;
      brighter = ((CMP_W'(pFinal) + CMP_W'(C)) * CMP_W'(N)) > CMP_W'(sumFinal);
   end

`ifdef ADAPTIVE_BOX_SKIP_BORDER_EN
   assign nextBorder = (baseCol < WIDTH_BITS'(RADIUS))  || (baseCol > ~WIDTH_BITS'(RADIUS)) ||
                       (baseRow < HEIGHT_BITS'(RADIUS)) || (baseRow > ~HEIGHT_BITS'(RADIUS));
`else
   assign nextBorder = 1'b0;
`endif

   assign startScan = processing && !nextBorder &&
                      ((state == IDLE) || ((state == WRITE) && !lastPixel));
   assign advance   = processing && (state == SCAN) && !lastTap;

   box_window_addr_gen #(
      .WIDTH_BITS (WIDTH_BITS),
      .HEIGHT_BITS(HEIGHT_BITS),
      .RADIUS     (RADIUS)
   ) uAddrGen (
      .clock    (clock),
      .not_reset(not_reset),
      .start    (startScan),
      .advance  (advance),
      .baseCol  (baseCol),
      .baseRow  (baseRow),
      .tapCol   (tapCol),
      .tapRow   (tapRow),
      .lastTap  (lastTap),
      .centreTap(centreTap)
   );

   assign bus.oImageCol = tapCol;
   assign bus.oImageRow = tapRow;

   // Frame FSM; result outputs are loaded on the edge entering WRITE, so C/invert are taken there.
   always_ff @(posedge clock) begin
      if (!not_reset) begin
         state           <= IDLE;
         pixCol          <= '0;
         pixRow          <= '0;
         sum             <= '0;
         p               <= '0;
         dataValid       <= 1'b0;
         centreValid     <= 1'b0;
         bus.oResultCol  <= '0;
         bus.oResultRow  <= '0;
         bus.oResultData <= 1'b0;
         bus.oResultWren <= 1'b0;
         finished        <= 1'b0;
      end else begin
         dataValid       <= (state == SCAN) && processing;
         centreValid     <= (state == SCAN) && processing && centreTap;
         bus.oResultWren <= 1'b0;
         case (state)
            IDLE: begin
               pixCol   <= '0;
               pixRow   <= '0;
               sum      <= '0;
               p        <= '0;
               finished <= 1'b0;
               if (processing) begin
                  if (nextBorder) begin
                     state           <= WRITE;
                     bus.oResultWren <= 1'b1;
                     bus.oResultCol  <= baseCol;
                     bus.oResultRow  <= baseRow;
                     bus.oResultData <= 1'b1 ^ invert;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (!processing) begin
                  state  <= IDLE;
                  pixCol <= '0;
                  pixRow <= '0;
                  sum    <= '0;
                  p      <= '0;
               end else begin
                  if (dataValid) begin
                     sum <= sumFinal;
                  end
                  if (centreValid) begin
                     p <= bus.iImageData;
                  end
                  if (lastTap) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!processing) begin
                  state  <= IDLE;
                  pixCol <= '0;
                  pixRow <= '0;
                  sum    <= '0;
                  p      <= '0;
               end else begin
                  sum             <= sumFinal;
                  p               <= pFinal;
                  state           <= WRITE;
                  bus.oResultWren <= 1'b1;
                  bus.oResultCol  <= pixCol;
                  bus.oResultRow  <= pixRow;
                  bus.oResultData <= brighter ^ invert;
               end
            end
            WRITE: begin
               sum <= '0;
               p   <= '0;
               if (!processing) begin
                  state  <= IDLE;
                  pixCol <= '0;
                  pixRow <= '0;
               end else if (lastPixel) begin
                  state    <= DONE;
                  finished <= 1'b1;
               end else begin
                  pixCol <= baseCol;
                  pixRow <= baseRow;
                  if (nextBorder) begin
                     state           <= WRITE;
                     bus.oResultWren <= 1'b1;
                     bus.oResultCol  <= baseCol;
                     bus.oResultRow  <= baseRow;
                     bus.oResultData <= 1'b1 ^ invert;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            DONE: begin
               if (!processing) begin
                  state    <= IDLE;
                  finished <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_adaptive_box_threshold.sv
// Directed bench for adaptive_box_threshold on an 8x8 image, RADIUS=1.
module tb_adaptive_box_threshold;
   import adaptive_box_pkg::*;

   localparam int WB = 3;
   localparam int HB = 3;
   localparam int R = 1;
   localparam int CB = 5;
   localparam int DIM = 8;
   localparam int NPIX = 64;
   localparam int PIXCYC = 11;

   logic          clock = 1'b0;
   logic          not_reset;
   logic          processing;
   logic [CB-1:0] C;
   logic          invert;
   logic          finished;

   adaptive_box_threshold_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) bus ();

   adaptive_box_threshold #(
      .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .RADIUS(R), .C_BITS(CB)
   ) dut (
      .clock     (clock),
      .not_reset (not_reset),
      .processing(processing),
      .C         (C),
      .invert    (invert),
      .finished  (finished),
      .bus       (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] img [0:DIM-1][0:DIM-1];

   // Synchronous ROM: data one cycle after the address.
   always @(posedge clock) bus.iImageData <= img[bus.oImageRow][bus.oImageCol];

   typedef struct {
      int         fill;
      int         sc;
      int         sr;
      logic [7:0] sv;
      logic [4:0] c;
      logic       inv;
      logic       expSpecial;
      logic       expOther;
   } vec_t;

   vec_t vecs [0:5];
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit isBorder(input int c, input int r);
      return (c < R) || (c > DIM - 1 - R) || (r < R) || (r > DIM - 1 - R);
   endfunction

   function automatic int expData(input int v, input int c, input int r);
`ifdef ADAPTIVE_BOX_SKIP_BORDER_EN
      if (isBorder(c, r)) return int'(1'b1 ^ vecs[v].inv);
`endif
      if (c == vecs[v].sc && r == vecs[v].sr) return int'(vecs[v].expSpecial);
      return int'(vecs[v].expOther);
   endfunction

   function automatic int expCycles();
      int total = 0;
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) begin
`ifdef ADAPTIVE_BOX_SKIP_BORDER_EN
            total += isBorder(c, r) ? 1 : PIXCYC;
`else
            total += PIXCYC;
`endif
         end
      end
      return total;
   endfunction

   task automatic loadImage(input int v);
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            img[r][c] = vecs[v].fill[7:0];
      if (vecs[v].sc >= 0) img[vecs[v].sr][vecs[v].sc] = vecs[v].sv;
      C = vecs[v].c;
      invert = vecs[v].inv;
   endtask

   task automatic runFrame(input int v);
      int writes = 0;
      int finCyc = -1;
      int prevCol;
      int prevRow;
      loadImage(v);
      @(negedge clock) processing = 1'b1;
      @(posedge clock);
      #1;
      prevCol = int'(bus.oImageCol);
      prevRow = int'(bus.oImageRow);
      for (int n = 1; n <= 3000; n++) begin
         @(posedge clock);
         #1;
         if (bus.oResultWren) begin
            check($sformatf("v%0d_write_col", v), int'(bus.oResultCol), writes % DIM);
            check($sformatf("v%0d_write_row", v), int'(bus.oResultRow), writes / DIM);
            check($sformatf("v%0d_data[%0d,%0d]", v, writes % DIM, writes / DIM),
                  int'(bus.oResultData), expData(v, writes % DIM, writes / DIM));
`ifdef ADAPTIVE_BOX_SKIP_BORDER_EN
            if (isBorder(writes % DIM, writes / DIM)) begin
               check($sformatf("v%0d_border_rom_col", v), int'(bus.oImageCol), prevCol);
               check($sformatf("v%0d_border_rom_row", v), int'(bus.oImageRow), prevRow);
            end
`endif
            writes++;
         end
         prevCol = int'(bus.oImageCol);
         prevRow = int'(bus.oImageRow);
         if (finished) begin
            finCyc = n;
            break;
         end
      end
      check($sformatf("v%0d_frame_cycles", v), finCyc, expCycles());
      check($sformatf("v%0d_write_count", v), writes, NPIX);
      @(negedge clock);
      check($sformatf("v%0d_finished_held", v), int'(finished), 1);
      check($sformatf("v%0d_wren_in_done", v), int'(bus.oResultWren), 0);
      processing = 1'b0;
      @(posedge clock);
      #1;
      check($sformatf("v%0d_finished_clear", v), int'(finished), 0);
   endtask

   initial begin
      int writes;
      int gapWrites;
      vecs[0] = '{100, -1, -1, 8'd0,   5'd2, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{100, -1, -1, 8'd0,   5'd0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{100, -1, -1, 8'd0,   5'd0, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{0,    5,  5, 8'd255, 5'd0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{0,    0,  0, 8'd90,  5'd0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{0,   -1, -1, 8'd0,   5'd0, 1'b0, 1'b0, 1'b0};

      not_reset  = 1'b0;
      processing = 1'b0;
      C          = '0;
      invert     = 1'b0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            img[r][c] = 8'd0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_wren", int'(bus.oResultWren), 0);
      check("rst_finished", int'(finished), 0);
      check("rst_data", int'(bus.oResultData), 0);
      check("rst_result_col", int'(bus.oResultCol), 0);
      check("rst_result_row", int'(bus.oResultRow), 0);
      check("rst_image_col", int'(bus.oImageCol), 0);
      check("rst_image_row", int'(bus.oImageRow), 0);
      @(negedge clock) not_reset = 1'b1;

      for (int v = 0; v < 6; v++) runFrame(v);

      // Abort during pixel 10, idle gap, then a clean restart from (0,0).
      loadImage(0);
      @(negedge clock) processing = 1'b1;
      writes = 0;
      for (int n = 0; n < 2000; n++) begin
         @(posedge clock);
         #1;
         if (bus.oResultWren) writes++;
         if (writes == 10) break;
      end
      check("abort_reached_pixel10", writes, 10);
      repeat (3) @(posedge clock);
      @(negedge clock) processing = 1'b0;
      gapWrites = 0;
      repeat (5) begin
         @(posedge clock);
         #1;
         if (bus.oResultWren) gapWrites++;
      end
      check("abort_gap_writes", gapWrites, 0);
      check("abort_gap_finished", int'(finished), 0);
      runFrame(0);

      // Reset mid-frame with processing still high.
      loadImage(0);
      @(negedge clock) processing = 1'b1;
      repeat (40) @(posedge clock);
      @(negedge clock) not_reset = 1'b0;
      @(posedge clock);
      #1;
      check("midrst_wren", int'(bus.oResultWren), 0);
      check("midrst_finished", int'(finished), 0);
      check("midrst_data", int'(bus.oResultData), 0);
      check("midrst_result_col", int'(bus.oResultCol), 0);
      check("midrst_result_row", int'(bus.oResultRow), 0);
      check("midrst_image_col", int'(bus.oImageCol), 0);
      check("midrst_image_row", int'(bus.oImageRow), 0);
      @(negedge clock);
      processing = 1'b0;
      not_reset  = 1'b1;
      repeat (2) @(posedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
